cpu_run_controller: RTL
=======================

Name: cpu_run_controller

Overview:
- Sequences CPU execution between the instruction loader and the CPU control unit.
- After the UART program load completes and the start switch is up, it grants execution one instruction at a time:
  - auto mode: back-to-back or throttled by a gap counter;
  - step mode: one instruction per next-instruction button pulse.
- It stops on HALT and flags a fault through a watchdog if an instruction never retires.
- It sits between the debounced board switches/buttons and the CPU core's execute enable.

Parameters:
AUTO_GAP, 16'd0, idle cycles inserted between instructions in auto mode; 0 = back-to-back
WATCHDOG_CYCLES, 16'd1024, max cycles in EXEC without i_instr_done before FAULT; 0 = watchdog disabled

Ports:
i_clk  input  1  system clock
i_rst_n  input  1  asynchronous active-low reset
i_instr_transmit_done  input  1  level; program load over UART complete
i_start_cpu  input  1  level; debounced start switch
i_step_mode  input  1  level; debounced step-execution switch (1 = step)
i_next_instr  input  1  one-cycle pulse; debounced next-instruction button
i_instr_done  input  1  one-cycle pulse from CPU; current instruction retired
i_halt  input  1  level from CPU; HALT executed
o_cpu_en  output  1  execute enable to the CPU control unit
o_state  output  3  current FSM state encoding (below)
o_instr_count  output  16  instructions retired since last start; saturates at 16'hFFFF
o_halted  output  1  high in HALTED
o_fault  output  1  high in FAULT

Behaviour:
- Reset (asynchronous, active-low) values:
  - State IDLE.
  - o_cpu_en=0, o_instr_count=0, o_halted=0, o_fault=0.
  - Gap and watchdog counters 0.
- State encoding: IDLE=0, LOADED=1, EXEC=2, GAP=3, STEP_WAIT=4, HALTED=5, FAULT=6.
- All outputs are registered and reflect the current state. o_cpu_en=1 iff state==EXEC, so it rises the cycle after the triggering event.
- IDLE:
  - i_instr_transmit_done=1 -> LOADED.
- LOADED:
  - i_start_cpu=1 -> clear o_instr_count.
  - Then go to STEP_WAIT if i_step_mode=1, else EXEC.
- EXEC:
  - The watchdog counter increments each cycle and clears on entry to EXEC.
  - On i_instr_done, o_instr_count increments (saturating), the watchdog clears, and the next state is chosen by priority:
    1. i_halt=1 -> HALTED.
    2. i_start_cpu=0 -> LOADED.
    3. i_step_mode=1 -> STEP_WAIT.
    4. AUTO_GAP=0 -> stay EXEC.
    5. Otherwise -> GAP, with the gap counter loaded to 0.
  - If WATCHDOG_CYCLES!=0, the watchdog count reaches WATCHDOG_CYCLES-1 and i_instr_done=0 -> FAULT.
  - i_instr_done in the expiry cycle wins over FAULT.
  - i_next_instr is ignored in EXEC; it is not queued.
  - A drop of i_start_cpu in EXEC is honoured only at the instruction boundary (i_instr_done).
- GAP:
  - The counter increments each cycle.
  - Priority: i_halt -> HALTED; i_start_cpu=0 -> LOADED; i_step_mode=1 -> STEP_WAIT; counter==AUTO_GAP-1 -> EXEC.
- STEP_WAIT:
  - Priority: i_halt -> HALTED; i_start_cpu=0 -> LOADED; i_step_mode=0 -> EXEC (auto resumes); i_next_instr -> EXEC.
  - Exactly one instruction runs per pulse; a pulse arriving in the same cycle as leaving STEP_WAIT is consumed.
- HALTED:
  - o_halted=1.
  - i_start_cpu=0 -> LOADED; the count is kept until the next start.
  - All other inputs are ignored.
- FAULT:
  - o_fault=1 and o_cpu_en=0.
  - Exit only by reset.
- i_instr_transmit_done falling after IDLE has no effect.
- Reset mid-EXEC drops o_cpu_en immediately (asynchronously).
- Unused encoding 7 -> IDLE on the next clock.

Test Plan:
- Load then auto run: transmit_done=1, start=1, step=0, AUTO_GAP=0; pulse instr_done 5x, halt=1 with the 5th -> o_cpu_en high from the cycle after start, o_instr_count=5, o_state=5, o_halted=1, o_cpu_en=0.
- Throttled auto: AUTO_GAP=3; instr_done pulse -> o_cpu_en low for exactly 3 cycles (state 3), then high again.
- Step mode: step=1, start=1 -> o_state=4, o_cpu_en=0. Next_instr pulse -> o_cpu_en=1 the next cycle until instr_done, then back to 4. A next_instr pulse during EXEC does not cause an extra instruction; the count is 1.
- Watchdog: WATCHDOG_CYCLES=8; EXEC with no instr_done -> o_state=6, o_fault=1 after 8 cycles. instr_done on the 8th cycle -> no fault.
- Abort/restart: start=0 in GAP -> LOADED immediately. Start=0 in EXEC -> LOADED only after instr_done. Start=1 again -> o_instr_count cleared to 0.
- Reset: assert i_rst_n=0 mid-EXEC -> o_cpu_en=0 and o_state=0 without a clock edge; after release, the FSM stays IDLE until transmit_done.

Source files
------------

// File: rtl/cpu_run_controller.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_run_controller
//  Description : Grants CPU execution one instruction at a time once the
//                program load is complete and the start switch is up.
//                Auto mode runs back-to-back or throttled by a gap counter;
//                step mode runs one instruction per next-instruction pulse.
//                Stops on HALT, and a watchdog faults if an instruction
//                never retires.
//  Ports       : i_clk, i_rst_n (async active-low)
//                i_instr_transmit_done, i_start_cpu, i_step_mode  - levels
//                i_next_instr, i_instr_done                      - pulses
//                i_halt                                          - level
//                o_cpu_en, o_state[2:0], o_instr_count[15:0],
//                o_halted, o_fault                               - registered
//  Revision    : 1.0 - initial release
// ============================================================================
module cpu_run_controller #(
    parameter logic [15:0] AUTO_GAP        = 16'd0,
    parameter logic [15:0] WATCHDOG_CYCLES = 16'd1024
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_instr_transmit_done,
    input  logic        i_start_cpu,
    input  logic        i_step_mode,
    input  logic        i_next_instr,
    input  logic        i_instr_done,
    input  logic        i_halt,
    output logic        o_cpu_en,
    output logic [2:0]  o_state,
    output logic [15:0] o_instr_count,
    output logic        o_halted,
    output logic        o_fault
);

    localparam logic [2:0] c_ST_IDLE      = 3'd0;
    localparam logic [2:0] c_ST_LOADED    = 3'd1;
    localparam logic [2:0] c_ST_EXEC      = 3'd2;
    localparam logic [2:0] c_ST_GAP       = 3'd3;
    localparam logic [2:0] c_ST_STEP_WAIT = 3'd4;
    localparam logic [2:0] c_ST_HALTED    = 3'd5;
    localparam logic [2:0] c_ST_FAULT     = 3'd6;

    localparam logic [15:0] c_GAP_LAST   = AUTO_GAP - 16'd1;
    localparam logic [15:0] c_WD_LAST    = WATCHDOG_CYCLES - 16'd1;
    localparam logic        c_GAP_ENABLE = (AUTO_GAP != 16'd0);
    localparam logic        c_WD_ENABLE  = (WATCHDOG_CYCLES != 16'd0);

    logic [2:0]  r_state;
    logic [15:0] r_gap_cnt;
    logic [15:0] r_wd_cnt;
    logic [15:0] r_instr_count;
    logic        r_cpu_en;
    logic        r_halted;
    logic        r_fault;

    logic [2:0]  w_next_state;
    logic        w_wd_expired;

    assign w_wd_expired = c_WD_ENABLE && (r_wd_cnt == c_WD_LAST);

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (i_instr_transmit_done) w_next_state = c_ST_LOADED;
            end
            c_ST_LOADED: begin
                if (i_start_cpu) w_next_state = i_step_mode ? c_ST_STEP_WAIT : c_ST_EXEC;
            end
            c_ST_EXEC: begin
                // A retiring instruction beats a watchdog expiry in the same cycle;
                // every other input is only looked at on the instruction boundary.
                if (i_instr_done) begin
                    if (i_halt)            w_next_state = c_ST_HALTED;
                    else if (!i_start_cpu) w_next_state = c_ST_LOADED;
                    else if (i_step_mode)  w_next_state = c_ST_STEP_WAIT;
                    else if (!c_GAP_ENABLE) w_next_state = c_ST_EXEC;
                    else                   w_next_state = c_ST_GAP;
                end else if (w_wd_expired) begin
                    w_next_state = c_ST_FAULT;
                end
            end
            c_ST_GAP: begin
                if (i_halt)                          w_next_state = c_ST_HALTED;
                else if (!i_start_cpu)               w_next_state = c_ST_LOADED;
                else if (i_step_mode)                w_next_state = c_ST_STEP_WAIT;
                else if (r_gap_cnt == c_GAP_LAST)    w_next_state = c_ST_EXEC;
            end
            c_ST_STEP_WAIT: begin
                // Leaving for EXEC consumes any next-instruction pulse of this cycle.
                if (i_halt)            w_next_state = c_ST_HALTED;
                else if (!i_start_cpu) w_next_state = c_ST_LOADED;
                else if (!i_step_mode) w_next_state = c_ST_EXEC;
                else if (i_next_instr) w_next_state = c_ST_EXEC;
            end
            c_ST_HALTED: begin
                if (!i_start_cpu) w_next_state = c_ST_LOADED;
            end
            c_ST_FAULT: begin
                w_next_state = c_ST_FAULT;
            end
            default: begin
                w_next_state = c_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= c_ST_IDLE;
            r_gap_cnt     <= 16'd0;
            r_wd_cnt      <= 16'd0;
            r_instr_count <= 16'd0;
            r_cpu_en      <= 1'b0;
            r_halted      <= 1'b0;
            r_fault       <= 1'b0;
        end else begin
            r_state  <= w_next_state;
            // Flags follow the state being entered so they line up with o_state.
            r_cpu_en <= (w_next_state == c_ST_EXEC);
            r_halted <= (w_next_state == c_ST_HALTED);
            r_fault  <= (w_next_state == c_ST_FAULT);

            // Watchdog restarts on every fresh instruction grant.
            if ((w_next_state == c_ST_EXEC) && ((r_state != c_ST_EXEC) || i_instr_done)) begin
                r_wd_cnt <= 16'd0;
            end else if (r_state == c_ST_EXEC) begin
                r_wd_cnt <= r_wd_cnt + 16'd1;
            end

            if ((w_next_state == c_ST_GAP) && (r_state != c_ST_GAP)) begin
                r_gap_cnt <= 16'd0;
            end else if (r_state == c_ST_GAP) begin
                r_gap_cnt <= r_gap_cnt + 16'd1;
            end

            if ((r_state == c_ST_LOADED) && i_start_cpu) begin
                r_instr_count <= 16'd0;
            end else if ((r_state == c_ST_EXEC) && i_instr_done && (r_instr_count != 16'hFFFF)) begin
                r_instr_count <= r_instr_count + 16'd1;
            end
        end
    end

    assign o_state       = r_state;
    assign o_cpu_en      = r_cpu_en;
    assign o_instr_count = r_instr_count;
    assign o_halted      = r_halted;
    assign o_fault       = r_fault;

endmodule
`default_nettype wire
